spi_fifo_master: RTL and testbench

//  Memory-mapped, write-only SPI master for the LCD path with a TX FIFO, per-frame D/C flag,

---
 rtl/spi_fifo_master.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_fifo_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_fifo_master.sv
// rtl/spi_fifo_master.sv - write-only SPI master for the LCD path with TX FIFO and per-frame D/C
//
// Purpose: software queues {dc, data} entries in a TX FIFO through a small register window.
//   The engine shifts each entry out as an 8- or 16-bit frame, MSB first, in any CPOL/CPHA mode.
//   The SCK half period is div+1 clocks. Chip select stays low across back-to-back frames.
//
// Ports:
//   clk, reset                     system clock, asynchronous active-high reset
//   address_in[3:2]                register select: 0 DATA, 1 CTRL, 2 STATUS, 3 CSCTL
//   sel_in, read_in                one-cycle access request, 1=read
//   write_mask_in, write_value_in  byte-lane enables and write data
//   read_value_out, ready_out      registered read data and acknowledge, one clock after sel_in
//   spi_clk, spi_mosi, spi_cs_n    SPI bus
//   lcd_dc                         LCD data/command select of the current frame (1=data)
//   irq_out                        enabled, FIFO empty and engine idle
module spi_fifo_master #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_RESET  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic [31:0] read_value_out,
  output logic        ready_out,
  output logic        spi_clk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic        lcd_dc,
  output logic        irq_out
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;
  state_t state;

  logic        ctrl_en, ctrl_w16, ctrl_cpol, ctrl_cphase, cs_hold, ovf;
  logic [7:0]  ctrl_div;

  // Frame configuration captured at frame start so register writes never disturb a frame.
  logic        act_w16, act_cphase;
  logic [7:0]  act_div;
  logic [7:0]  hcnt;
  logic [5:0]  edge_cnt;
  logic [15:0] shreg;

  logic [16:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          fifo_full, fifo_empty;

  logic        bus_wr, bus_rd;
  logic [1:0]  reg_sel;
  logic        push_req, push, pop, flush_req, ovf_clr;
  logic        frame_start, half_done, busy;
  logic [16:0] head;
  logic [15:0] load_word;
  logic [5:0]  last_edge;
  logic [31:0] rdata;
  logic        unused_bits;

  assign unused_bits = ^{address_in[31:4], address_in[1:0], write_mask_in[3:2], write_value_in[31:17]};

  assign reg_sel    = address_in[3:2];
  assign bus_wr     = sel_in & ~read_in;
  assign bus_rd     = sel_in & read_in;
  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  assign busy       = (state != IDLE);

  assign push_req  = bus_wr && (reg_sel == 2'd0) && write_mask_in[0];
  assign flush_req = bus_wr && (reg_sel == 2'd1) && write_mask_in[0] && write_value_in[4];
  assign ovf_clr   = bus_wr && (reg_sel == 2'd2) && write_mask_in[0] && write_value_in[3];

  assign half_done = (hcnt == act_div);
  // A flush in the same cycle wins over starting a new frame from the head entry.
  assign frame_start = ctrl_en && !fifo_empty && !flush_req &&
                       ((state == IDLE) || ((state == GAP) && half_done));
  assign pop  = frame_start;
  // A push into a full FIFO still lands when the engine pops in the same cycle.
  assign push = push_req && (!fifo_full || pop);

  assign head      = mem[rd_ptr];
  assign load_word = ctrl_w16 ? head[15:0] : {head[7:0], 8'h00};
  assign last_edge = act_w16 ? 6'd32 : 6'd16;
  assign irq_out   = ctrl_en && fifo_empty && (state == IDLE);

  always_comb begin
    rdata = 32'h0;
    case (reg_sel)
      2'd1:    rdata = {16'h0, ctrl_div, 4'h0, ctrl_cphase, ctrl_cpol, ctrl_w16, ctrl_en};
      2'd2:    rdata = {16'h0, 8'(level), 4'h0, ovf, fifo_empty, fifo_full, busy};
      2'd3:    rdata = {31'h0, cs_hold};
      default: rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_out      <= 1'b0;
      read_value_out <= 32'h0;
      ctrl_en        <= 1'b0;
      ctrl_w16       <= 1'b0;
      ctrl_cpol      <= 1'b0;
      ctrl_cphase    <= 1'b0;
      ctrl_div       <= 8'(DIV_RESET);
      cs_hold        <= 1'b0;
    end else begin
      ready_out      <= sel_in;
      read_value_out <= bus_rd ? rdata : 32'h0;
      if (bus_wr && (reg_sel == 2'd1)) begin
        if (write_mask_in[0]) begin
          ctrl_en     <= write_value_in[0];
          ctrl_w16    <= write_value_in[1];
          ctrl_cpol   <= write_value_in[2];
          ctrl_cphase <= write_value_in[3];
        end
        if (write_mask_in[1]) ctrl_div <= write_value_in[15:8];
      end
      if (bus_wr && (reg_sel == 2'd3) && write_mask_in[0]) cs_hold <= write_value_in[0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= write_value_in[16:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (flush_req) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      level <= level + 1'b1;
        else if (!push && pop) level <= level - 1'b1;
      end
      if (push_req && fifo_full && !pop) ovf <= 1'b1;
      else if (ovf_clr)                  ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      spi_clk    <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_cs_n   <= 1'b1;
      lcd_dc     <= 1'b0;
      hcnt       <= 8'h0;
      edge_cnt   <= 6'h0;
      shreg      <= 16'h0;
      act_w16    <= 1'b0;
      act_cphase <= 1'b0;
      act_div    <= 8'(DIV_RESET);
    end else begin
      case (state)
        IDLE: begin
          spi_clk <= ctrl_cpol;
          if (!cs_hold) spi_cs_n <= 1'b1;
        end
        SETUP: begin
          if (half_done) begin
            hcnt     <= 8'h0;
            state    <= SHIFT;
            spi_clk  <= ~spi_clk;
            edge_cnt <= 6'd1;
            // CPHA=1 presents the MSB on the first (leading) edge.
            if (act_cphase) begin
              spi_mosi <= shreg[15];
              shreg    <= shreg << 1;
            end
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
        SHIFT: begin
          if (half_done) begin
            hcnt <= 8'h0;
            if (edge_cnt == last_edge) begin
              state <= GAP;
            end else begin
              spi_clk  <= ~spi_clk;
              edge_cnt <= edge_cnt + 6'd1;
              // Upcoming edge number is edge_cnt+1: CPHA=0 drives on even edges, CPHA=1 on odd.
              if (edge_cnt[0] != act_cphase) begin
                spi_mosi <= shreg[15];
                shreg    <= shreg << 1;
              end
            end
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
        GAP: begin
          if (half_done) begin
            hcnt <= 8'h0;
            if (!frame_start) begin
              state    <= IDLE;
              spi_cs_n <= ~cs_hold;
            end
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (frame_start) begin
        state      <= SETUP;
        hcnt       <= 8'h0;
        spi_cs_n   <= 1'b0;
        lcd_dc     <= head[16];
        act_w16    <= ctrl_w16;
        act_cphase <= ctrl_cphase;
        act_div    <= ctrl_div;
        if (ctrl_cphase) begin
          shreg <= load_word;
        end else begin
          spi_mosi <= load_word[15];
          shreg    <= load_word << 1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_fifo_master.sv
// tb/tb_spi_fifo_master.sv - directed self-checking bench for spi_fifo_master
module tb_spi_fifo_master;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic [31:0] read_value_out;
  logic        ready_out;
  logic        spi_clk, spi_mosi, spi_cs_n, lcd_dc, irq_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_fifo_master #(.FIFO_DEPTH(16), .DIV_RESET(4)) dut (
    .clk(clk), .reset(reset), .address_in(address_in), .sel_in(sel_in), .read_in(read_in),
    .write_mask_in(write_mask_in), .write_value_in(write_value_in),
    .read_value_out(read_value_out), .ready_out(ready_out), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .lcd_dc(lcd_dc), .irq_out(irq_out)
  );

  logic [31:0] cap_bits, cap_dc;
  int cap_nbits, cap_pulses, cap_period, cap_falls, cap_dc_changes, cap_dc_change_at;
  bit cap_done, cap_bad_idle;

  task automatic bus_write(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    @(negedge clk);
    address_in = addr; write_mask_in = mask; write_value_in = data; read_in = 1'b0; sel_in = 1'b1;
    @(negedge clk);
    sel_in = 1'b0; write_mask_in = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic rdy);
    @(negedge clk);
    address_in = addr; read_in = 1'b1; sel_in = 1'b1;
    @(negedge clk);
    sel_in = 1'b0; read_in = 1'b0;
    data = read_value_out; rdy = ready_out;
  endtask

  // Records bits at the sampling edge of the given mode until CS rises after a low window.
  task automatic capture(input logic cpol, input logic cpha, input int budget);
    logic prev_clk, prev_cs, prev_dc;
    int last_rise;
    cap_bits = '0; cap_dc = '0; cap_nbits = 0; cap_pulses = 0; cap_period = 0; cap_falls = 0;
    cap_dc_changes = 0; cap_dc_change_at = -1; cap_done = 0; cap_bad_idle = 0; last_rise = -1;
    prev_clk = spi_clk; prev_cs = spi_cs_n; prev_dc = lcd_dc;
    for (int cyc = 0; cyc < budget && !cap_done; cyc++) begin
      @(negedge clk);
      if (spi_clk !== prev_clk) begin
        if (spi_clk === (cpol == cpha)) begin
          if (cap_nbits < 32) begin
            cap_bits[31-cap_nbits] = spi_mosi;
            cap_dc[31-cap_nbits] = lcd_dc;
          end
          cap_nbits++;
        end
        if (spi_clk !== cpol) cap_pulses++;
        if (spi_clk === 1'b1) begin
          if (last_rise >= 0 && cap_period == 0) cap_period = cyc - last_rise;
          last_rise = cyc;
        end
      end
      if (prev_cs === 1'b1 && spi_cs_n === 1'b0) cap_falls++;
      if (prev_cs === 1'b0 && spi_cs_n === 1'b0 && lcd_dc !== prev_dc) begin
        cap_dc_changes++;
        cap_dc_change_at = cap_pulses;
      end
      if (spi_cs_n === 1'b1 && spi_clk !== cpol) cap_bad_idle = 1;
      if (cap_falls > 0 && spi_cs_n === 1'b1) cap_done = 1;
      prev_clk = spi_clk; prev_cs = spi_cs_n; prev_dc = lcd_dc;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic rdy;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (spi_clk !== 1'b0) begin failures++; $display("FAIL reset_sck got %b exp 0", spi_clk); end
    checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs got %b exp 1", spi_cs_n); end
    checks++; if (spi_mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi got %b exp 0", spi_mosi); end
    checks++; if (lcd_dc !== 1'b0) begin failures++; $display("FAIL reset_dc got %b exp 0", lcd_dc); end
    checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL reset_ready got %b exp 0", ready_out); end
    checks++; if (read_value_out !== 32'h0) begin failures++; $display("FAIL reset_rdata got %h exp 0", read_value_out); end
    checks++; if (irq_out !== 1'b0) begin failures++; $display("FAIL reset_irq got %b exp 0", irq_out); end
    @(negedge clk);
    reset = 1'b0;
    bus_read(32'h8, rd, rdy);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL reset_ack got %b exp 1", rdy); end
    checks++; if (rd !== 32'h4) begin failures++; $display("FAIL reset_status got %h exp 00000004", rd); end
    bus_read(32'h4, rd, rdy);
    checks++; if (rd !== 32'h0400) begin failures++; $display("FAIL reset_ctrl got %h exp 00000400", rd); end
    bus_read(32'hC, rd, rdy);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_csctl got %h exp 0", rd); end
  endtask

  task automatic test_single_byte();
    bus_write(32'h4, 4'hF, 32'h0100);
    bus_write(32'h0, 4'hF, 32'h0001_00A5);
    bus_write(32'h4, 4'hF, 32'h0101);
    capture(1'b0, 1'b0, 200);
    checks++; if (!cap_done) begin failures++; $display("FAIL t1_done got 0 exp 1"); end
    checks++; if (cap_nbits != 8) begin failures++; $display("FAIL t1_nbits got %0d exp 8", cap_nbits); end
    checks++; if (cap_bits[31:24] !== 8'hA5) begin failures++; $display("FAIL t1_data got %h exp a5", cap_bits[31:24]); end
    checks++; if (cap_pulses != 8) begin failures++; $display("FAIL t1_pulses got %0d exp 8", cap_pulses); end
    checks++; if (cap_period != 4) begin failures++; $display("FAIL t1_period got %0d exp 4", cap_period); end
    checks++; if (cap_dc[31:24] !== 8'hFF) begin failures++; $display("FAIL t1_dc got %h exp ff", cap_dc[31:24]); end
    checks++; if (cap_bad_idle) begin failures++; $display("FAIL t1_idle_sck got 1 exp 0"); end
    checks++; if (irq_out !== 1'b1) begin failures++; $display("FAIL t1_irq got %b exp 1", irq_out); end
    repeat (3) @(negedge clk);
    checks++; if (lcd_dc !== 1'b1) begin failures++; $display("FAIL t1_dc_hold got %b exp 1", lcd_dc); end
  endtask

  task automatic test_back_to_back();
    bus_write(32'h4, 4'hF, 32'h0100);
    bus_write(32'h0, 4'hF, 32'h0000_002A);
    bus_write(32'h0, 4'hF, 32'h0001_1234);
    fork
      capture(1'b0, 1'b0, 400);
      begin
        bus_write(32'h4, 4'hF, 32'h0101);
        bus_write(32'h4, 4'hF, 32'h0103);
      end
    join
    checks++; if (!cap_done) begin failures++; $display("FAIL t2_done got 0 exp 1"); end
    checks++; if (cap_falls != 1) begin failures++; $display("FAIL t2_cs_windows got %0d exp 1", cap_falls); end
    checks++; if (cap_nbits != 24) begin failures++; $display("FAIL t2_nbits got %0d exp 24", cap_nbits); end
    checks++; if (cap_bits[31:24] !== 8'h2A) begin failures++; $display("FAIL t2_byte got %h exp 2a", cap_bits[31:24]); end
    checks++; if (cap_bits[23:8] !== 16'h1234) begin failures++; $display("FAIL t2_word got %h exp 1234", cap_bits[23:8]); end
    checks++; if (cap_dc[31:8] !== 24'h00FFFF) begin failures++; $display("FAIL t2_dc got %h exp 00ffff", cap_dc[31:8]); end
    checks++; if (cap_dc_changes != 1) begin failures++; $display("FAIL t2_dc_changes got %0d exp 1", cap_dc_changes); end
    checks++; if (cap_dc_change_at != 8) begin failures++; $display("FAIL t2_dc_change_at got %0d exp 8", cap_dc_change_at); end
    checks++; if (cap_pulses != 24) begin failures++; $display("FAIL t2_pulses got %0d exp 24", cap_pulses); end
  endtask

  task automatic test_modes();
    logic cpol, cpha;
    logic [31:0] ctrl;
    for (int m = 1; m < 4; m++) begin
      cpol = m[1]; cpha = m[0];
      ctrl = {28'h0, cpha, cpol, 2'b00};
      bus_write(32'h4, 4'hF, ctrl);
      repeat (2) @(negedge clk);
      checks++; if (spi_clk !== cpol) begin failures++; $display("FAIL t3_idle_m%0d got %b exp %b", m, spi_clk, cpol); end
      bus_write(32'h0, 4'hF, 32'h0001_0081);
      bus_write(32'h4, 4'hF, ctrl | 32'h1);
      capture(cpol, cpha, 200);
      checks++; if (!cap_done) begin failures++; $display("FAIL t3_done_m%0d got 0 exp 1", m); end
      checks++; if (cap_nbits != 8) begin failures++; $display("FAIL t3_nbits_m%0d got %0d exp 8", m, cap_nbits); end
      checks++; if (cap_bits[31:24] !== 8'h81) begin failures++; $display("FAIL t3_data_m%0d got %h exp 81", m, cap_bits[31:24]); end
      checks++; if (cap_pulses != 8) begin failures++; $display("FAIL t3_pulses_m%0d got %0d exp 8", m, cap_pulses); end
      checks++; if (cap_bad_idle) begin failures++; $display("FAIL t3_idle_sck_m%0d got 1 exp 0", m); end
    end
    bus_write(32'h4, 4'hF, 32'h0);
  endtask

  task automatic test_fifo_flags();
    logic [31:0] rd;
    logic rdy;
    bus_write(32'h4, 4'hF, 32'h0100);
    for (int i = 0; i < 17; i++) bus_write(32'h0, 4'hF, 32'(i));
    bus_read(32'h8, rd, rdy);
    checks++; if (rd !== 32'h0000_100A) begin failures++; $display("FAIL t4_full_status got %h exp 0000100a", rd); end
    bus_read(32'h0, rd, rdy);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL t4_data_read got %h exp 0", rd); end
    bus_write(32'h8, 4'hF, 32'h8);
    bus_read(32'h8, rd, rdy);
    checks++; if (rd !== 32'h0000_1002) begin failures++; $display("FAIL t4_ovf_clear got %h exp 00001002", rd); end
    bus_write(32'h4, 4'h1, 32'h10);
    bus_read(32'h8, rd, rdy);
    checks++; if (rd !== 32'h4) begin failures++; $display("FAIL t4_flush_status got %h exp 00000004", rd); end
    bus_read(32'h4, rd, rdy);
    checks++; if (rd !== 32'h0100) begin failures++; $display("FAIL t4_ctrl_after_flush got %h exp 00000100", rd); end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] rd;
    logic rdy;
    bit hit;
    bus_write(32'h4, 4'hF, 32'h0302);
    bus_write(32'h0, 4'hF, 32'h0001_FFFF);
    bus_write(32'h4, 4'hF, 32'h0303);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (spi_clk === 1'b1) hit = 1;
    end
    checks++; if (!hit) begin failures++; $display("FAIL t5_sck_timeout got 0 exp 1"); end
    checks++; if (spi_cs_n !== 1'b0 || spi_mosi !== 1'b1) begin failures++; $display("FAIL t5_pre_cs_mosi got %b%b exp 01", spi_cs_n, spi_mosi); end
    reset = 1'b1;
    #1;
    checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL t5_cs got %b exp 1", spi_cs_n); end
    checks++; if (spi_clk !== 1'b0) begin failures++; $display("FAIL t5_sck got %b exp 0", spi_clk); end
    checks++; if (spi_mosi !== 1'b0) begin failures++; $display("FAIL t5_mosi got %b exp 0", spi_mosi); end
    checks++; if (lcd_dc !== 1'b0) begin failures++; $display("FAIL t5_dc got %b exp 0", lcd_dc); end
    @(negedge clk);
    reset = 1'b0;
    bus_read(32'h8, rd, rdy);
    checks++; if (rd !== 32'h4) begin failures++; $display("FAIL t5_status got %h exp 00000004", rd); end
    bus_read(32'h4, rd, rdy);
    checks++; if (rd !== 32'h0400) begin failures++; $display("FAIL t5_ctrl got %h exp 00000400", rd); end
  endtask

  task automatic test_cs_hold();
    logic irq_mid, cs_mid;
    bit seen_low, broke;
    int pulses;
    logic prev_clk;
    bus_write(32'hC, 4'hF, 32'h1);
    bus_write(32'h4, 4'hF, 32'h0001);
    seen_low = 0; broke = 0; pulses = 0; irq_mid = 1'b0; cs_mid = 1'b1;
    prev_clk = spi_clk;
    fork
      begin
        bus_write(32'h0, 4'hF, 32'h0001_0055);
        repeat (25) @(negedge clk);
        irq_mid = irq_out; cs_mid = spi_cs_n;
        bus_write(32'h0, 4'hF, 32'h0001_00AA);
      end
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (spi_cs_n === 1'b0) seen_low = 1;
        else if (seen_low) broke = 1;
        if (spi_clk === 1'b1 && prev_clk === 1'b0) pulses++;
        prev_clk = spi_clk;
      end
    join
    checks++; if (!seen_low) begin failures++; $display("FAIL t6_cs_low got 0 exp 1"); end
    checks++; if (broke) begin failures++; $display("FAIL t6_cs_break got 1 exp 0"); end
    checks++; if (irq_mid !== 1'b1) begin failures++; $display("FAIL t6_irq_between got %b exp 1", irq_mid); end
    checks++; if (cs_mid !== 1'b0) begin failures++; $display("FAIL t6_cs_between got %b exp 0", cs_mid); end
    checks++; if (pulses != 16) begin failures++; $display("FAIL t6_pulses got %0d exp 16", pulses); end
    checks++; if (lcd_dc !== 1'b1) begin failures++; $display("FAIL t6_dc_hold got %b exp 1", lcd_dc); end
    bus_write(32'hC, 4'hF, 32'h0);
    @(negedge clk);
    checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL t6_cs_release got %b exp 1", spi_cs_n); end
  endtask

  initial begin
    reset = 1'b1; sel_in = 1'b0; read_in = 1'b0; address_in = 32'h0;
    write_mask_in = 4'h0; write_value_in = 32'h0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_modes();
    test_fifo_flags();
    test_reset_mid_shift();
    test_cs_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
